// File: rtl/label_allocator_if.sv
// Request/response, label-table and memory-write signals of the label allocator.
// The executor side uses the master modport; the allocator uses the slave modport.
interface label_allocator_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned LBIDX_W = 6,
   parameter int unsigned DATA_W  = 32
);
   logic               req_valid;
   logic               req_ready;
   logic [LBIDX_W-1:0] req_lbidx;
   logic [5:0]         req_type;
   logic [ADDR_W-1:0]  req_count;
   logic               req_clear;
   logic               free_all;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [1:0]         rsp_err;
   logic [ADDR_W-1:0]  rsp_base;

   logic               lbt_we;
   logic [LBIDX_W-1:0] lbt_idx;
   logic [ADDR_W-1:0]  lbt_base;
   logic [ADDR_W-1:0]  lbt_count;
   logic [5:0]         lbt_type;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;

   logic [ADDR_W:0]    used;

   modport master (
      output req_valid, req_lbidx, req_type, req_count, req_clear, free_all, rsp_ready,
      input  req_ready, rsp_valid, rsp_err, rsp_base,
      input  lbt_we, lbt_idx, lbt_base, lbt_count, lbt_type,
      input  mem_we, mem_addr, mem_wdata, used
   );

   modport slave (
      input  req_valid, req_lbidx, req_type, req_count, req_clear, free_all, rsp_ready,
      output req_ready, rsp_valid, rsp_err, rsp_base,
      output lbt_we, lbt_idx, lbt_base, lbt_count, lbt_type,
      output mem_we, mem_addr, mem_wdata, used
   );
endinterface

// File: rtl/label_allocator.sv
// Bump-pointer allocator for label-table regions: validates a request, optionally zero-fills
// the region through the memory port, then commits {base,count,type} to the label table.
module label_allocator #(
   parameter int unsigned       ADDR_W    = 16,
   parameter int unsigned       LBIDX_W   = 6,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] POOL_BASE = '0,
   parameter logic [ADDR_W-1:0] POOL_END  = '1
) (
   input logic                clk,
   input logic                rst_n,
   label_allocator_if.slave   bus
);

   // Label type encoding shared with the address decoder.
   localparam logic [5:0] LbtUndefined = 6'd0;
   localparam logic [5:0] LbtVptr      = 6'd1;
   localparam logic [5:0] LbtSint8     = 6'd2;
   localparam logic [5:0] LbtUint8     = 6'd3;
   localparam logic [5:0] LbtSint16    = 6'd4;
   localparam logic [5:0] LbtUint16    = 6'd5;
   localparam logic [5:0] LbtSint32    = 6'd6;
   localparam logic [5:0] LbtUint32    = 6'd7;
   localparam logic [5:0] LbtSint4     = 6'd8;
   localparam logic [5:0] LbtUint4     = 6'd9;
   localparam logic [5:0] LbtSint2     = 6'd10;
   localparam logic [5:0] LbtUint2     = 6'd11;
   localparam logic [5:0] LbtSint1     = 6'd12;
   localparam logic [5:0] LbtUint1     = 6'd13;
   localparam logic [5:0] LbtCode      = 6'd14;

   localparam logic [ADDR_W:0] PoolStart = {1'b0, POOL_BASE};
   localparam logic [ADDR_W:0] PoolLimit = {1'b0, POOL_END} + {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StFill,
      StCommit,
      StResp
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W:0]    ptr_q, ptr_d;
   logic [LBIDX_W-1:0] idx_q, idx_d;
   logic [5:0]         type_q, type_d;
   logic [ADDR_W-1:0]  count_q, count_d;
   logic               clear_q, clear_d;
   logic [ADDR_W-1:0]  fill_q, fill_d;
   logic [1:0]         err_q, err_d;
   logic [ADDR_W-1:0]  base_q, base_d;

   logic               type_ok;
   logic [ADDR_W:0]    end_ptr;

   always_comb begin
      type_ok = 1'b0;
      unique case (type_q)
         LbtVptr, LbtSint8, LbtUint8, LbtSint16, LbtUint16, LbtSint32, LbtUint32,
         LbtSint4, LbtUint4, LbtSint2, LbtUint2, LbtSint1, LbtUint1, LbtCode: type_ok = 1'b1;
         default: type_ok = 1'b0;
      endcase
   end

   // ptr never exceeds PoolLimit and count fits ADDR_W, so this sum cannot wrap.
   assign end_ptr = ptr_q + {1'b0, count_q};

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      type_d    = type_q;
      count_d   = count_q;
      clear_d   = clear_q;
      fill_d    = fill_q;
      err_d     = err_q;
      base_d    = base_q;

      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 2'd0;
      bus.rsp_base  = '0;
      bus.lbt_we    = 1'b0;
      bus.lbt_idx   = '0;
      bus.lbt_base  = '0;
      bus.lbt_count = '0;
      bus.lbt_type  = 6'd0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;

      unique case (state_q)
         StIdle: begin
            bus.req_ready = !bus.free_all;
            if (bus.free_all) begin
               ptr_d = PoolStart;
            end else if (bus.req_valid) begin
               idx_d   = bus.req_lbidx;
               type_d  = bus.req_type;
               count_d = bus.req_count;
               clear_d = bus.req_clear;
               state_d = StCheck;
            end
         end
         StCheck: begin
            fill_d = '0;
            if (!type_ok) begin
               err_d   = 2'd1;
               base_d  = '0;
               state_d = StResp;
            end else if (count_q == '0) begin
               err_d   = 2'd2;
               base_d  = '0;
               state_d = StResp;
            end else if (end_ptr > PoolLimit) begin
               err_d   = 2'd3;
               base_d  = '0;
               state_d = StResp;
            end else begin
               err_d   = 2'd0;
               base_d  = ptr_q[ADDR_W-1:0];
               state_d = clear_q ? StFill : StCommit;
            end
         end
         StFill: begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = ptr_q[ADDR_W-1:0] + fill_q;
            fill_d       = fill_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (fill_q == count_q - {{(ADDR_W-1){1'b0}}, 1'b1}) begin
               state_d = StCommit;
            end
         end
         StCommit: begin
            bus.lbt_we    = 1'b1;
            bus.lbt_idx   = idx_q;
            bus.lbt_base  = ptr_q[ADDR_W-1:0];
            bus.lbt_count = count_q;
            bus.lbt_type  = type_q;
            ptr_d         = end_ptr;
            state_d       = StResp;
         end
         StResp: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            bus.rsp_base  = base_q;
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A reset cycle aborts whatever is in flight, so no strobe may escape during it.
      if (!rst_n) begin
         bus.req_ready = 1'b0;
         bus.rsp_valid = 1'b0;
         bus.lbt_we    = 1'b0;
         bus.mem_we    = 1'b0;
      end
   end

   assign bus.mem_wdata = '0;
   assign bus.used      = ptr_q - PoolStart;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= PoolStart;
         idx_q   <= '0;
         type_q  <= LbtUndefined;
         count_q <= '0;
         clear_q <= 1'b0;
         fill_q  <= '0;
         err_q   <= 2'd0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         type_q  <= type_d;
         count_q <= count_d;
         clear_q <= clear_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
         base_q  <= base_d;
      end
   end

endmodule

// File: tb/tb_label_allocator.sv
// Directed bench for label_allocator with a 256-word pool at 0x0100..0x01FF.
module tb_label_allocator;

   localparam logic [5:0] TyUndef  = 6'd0;
   localparam logic [5:0] TyUint8  = 6'd3;
   localparam logic [5:0] TySint16 = 6'd4;
   localparam logic [5:0] TyUint32 = 6'd7;
   localparam logic [5:0] TyCode   = 6'd14;
   localparam logic [5:0] TyBogus  = 6'd20;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   label_allocator_if #(.ADDR_W(16), .LBIDX_W(6), .DATA_W(32)) bus ();

   label_allocator #(
      .ADDR_W   (16),
      .LBIDX_W  (6),
      .DATA_W   (32),
      .POOL_BASE(16'h0100),
      .POOL_END (16'h01FF)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it to its response, checking every strobe on the way.
   task automatic alloc(input logic [5:0] idx, input logic [5:0] ty, input logic [15:0] cnt,
                        input logic clr, input logic [1:0] eerr, input logic [15:0] ebase);
      int c, lbt_c, rsp_c, nfill, nlbt, waits;
      waits = 0;
      while (!bus.req_ready && waits < 20) begin
         tick();
         waits++;
      end
      check("req_ready", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_lbidx = idx;
      bus.req_type  = ty;
      bus.req_count = cnt;
      bus.req_clear = clr;
      tick();
      bus.req_valid = 1'b0;
      c = 1; lbt_c = -1; rsp_c = -1; nfill = 0; nlbt = 0;
      while (c < 400) begin
         if (bus.mem_we) begin
            check("fill_addr", 64'(bus.mem_addr), 64'(ebase + 16'(nfill)));
            check("fill_data", 64'(bus.mem_wdata), 64'd0);
            nfill++;
         end
         if (bus.lbt_we) begin
            nlbt++;
            lbt_c = c;
            check("lbt_entry", 64'({bus.lbt_idx, bus.lbt_base, bus.lbt_count, bus.lbt_type}),
                  64'({idx, ebase, cnt, ty}));
         end
         if (bus.rsp_valid) begin
            rsp_c = c;
            break;
         end
         tick();
         c++;
      end
      check("lbt_we_count", 64'(nlbt), (eerr == 2'd0) ? 64'd1 : 64'd0);
      check("fill_words", 64'(nfill), (eerr == 2'd0 && clr) ? 64'(cnt) : 64'd0);
      if (eerr == 2'd0) check("lbt_latency", 64'(lbt_c), clr ? 64'(cnt) + 64'd2 : 64'd2);
      check("rsp_latency", 64'(rsp_c),
            (eerr != 2'd0) ? 64'd2 : (clr ? 64'(cnt) + 64'd3 : 64'd3));
      check("rsp_err", 64'(bus.rsp_err), 64'(eerr));
      check("rsp_base", 64'(bus.rsp_base), 64'(ebase));
      if (bus.rsp_ready) begin
         tick();
         check("rsp_drop", 64'(bus.rsp_valid), 64'd0);
      end
   endtask

   initial begin
      int strays;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_lbidx = '0;
      bus.req_type  = '0;
      bus.req_count = '0;
      bus.req_clear = 1'b0;
      bus.free_all  = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (3) tick();
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_outputs", 64'({bus.rsp_valid, bus.lbt_we, bus.mem_we}), 64'd0);
      check("rst_used", 64'(bus.used), 64'd0);
      rst_n = 1'b1;
      tick();

      // Plain allocation, then one with zero-fill.
      alloc(6'd3, TyCode, 16'h0010, 1'b0, 2'd0, 16'h0100);
      check("used_t1", 64'(bus.used), 64'd16);
      alloc(6'd4, TyUint8, 16'h0004, 1'b1, 2'd0, 16'h0110);
      check("used_t2", 64'(bus.used), 64'd20);

      // Rejected requests leave the pool alone.
      alloc(6'd5, TyUndef, 16'h0008, 1'b0, 2'd1, 16'h0000);
      alloc(6'd5, TyBogus, 16'h0008, 1'b1, 2'd1, 16'h0000);
      alloc(6'd5, TyUint8, 16'h0000, 1'b1, 2'd2, 16'h0000);
      alloc(6'd5, TyUint8, 16'h00ED, 1'b0, 2'd3, 16'h0000);
      check("used_t3", 64'(bus.used), 64'd20);

      // Exact fit consumes the last word; nothing more fits afterwards.
      alloc(6'd6, TyUint32, 16'h00EC, 1'b0, 2'd0, 16'h0114);
      check("used_t4", 64'(bus.used), 64'd256);
      alloc(6'd7, TyUint8, 16'h0001, 1'b0, 2'd3, 16'h0000);
      check("used_t4b", 64'(bus.used), 64'd256);

      // free_all wins over a simultaneous request.
      bus.free_all  = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_type  = TyUint8;
      bus.req_count = 16'h0001;
      #1;
      check("free_blocks_ready", 64'(bus.req_ready), 64'd0);
      tick();
      check("free_used", 64'(bus.used), 64'd0);
      check("free_no_accept", 64'({bus.req_ready, bus.rsp_valid, bus.lbt_we, bus.mem_we}),
            64'd0);
      bus.free_all  = 1'b0;
      bus.req_valid = 1'b0;
      alloc(6'd8, TySint16, 16'h0001, 1'b0, 2'd0, 16'h0100);
      check("used_t5", 64'(bus.used), 64'd1);

      // Reset in the middle of a zero-fill aborts the request.
      bus.req_valid = 1'b1;
      bus.req_lbidx = 6'd9;
      bus.req_type  = TyUint8;
      bus.req_count = 16'h0008;
      bus.req_clear = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      check("midfill_we", 64'(bus.mem_we), 64'd1);
      rst_n = 1'b0;
      strays = 0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (bus.lbt_we || bus.rsp_valid || bus.mem_we) strays++;
         tick();
      end
      check("abort_strays", 64'(strays), 64'd0);
      check("abort_used", 64'(bus.used), 64'd0);

      // Response must hold steady while the consumer stalls.
      bus.rsp_ready = 1'b0;
      alloc(6'd10, TyUint8, 16'h0002, 1'b0, 2'd0, 16'h0100);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_base}),
               64'({1'b1, 2'd0, 16'h0100}));
      end
      check("hold_no_ready", 64'(bus.req_ready), 64'd0);
      bus.rsp_ready = 1'b1;
      tick();
      check("hold_release", 64'(bus.rsp_valid), 64'd0);
      check("used_t6", 64'(bus.used), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
